// File: rtl/pu_mac_pkg.sv
// Shared types and helpers for the PU window MAC: FSM state encoding,
// default widths and the shift-and-saturate used to produce the pixel result.
package pu_mac_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FRAC_BITS = 8;
  localparam int DEF_ACC_W     = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } mac_state_t;

  // Arithmetic shift back to Q(DATA_W-FRAC).FRAC, then clamp to the signed DATA_W range.
  // The result fits iff every bit from DATA_W-1 up is a copy of the sign.
  function automatic logic [DEF_DATA_W-1:0] sat_shift(
    input logic signed [DEF_ACC_W-1:0] acc,
    input int unsigned                 frac = DEF_FRAC_BITS
  );
    logic signed [DEF_ACC_W-1:0]         sh;
    logic        [DEF_ACC_W-DEF_DATA_W:0] top;
    sh  = acc >>> frac;
    top = sh[DEF_ACC_W-1:DEF_DATA_W-1];
    if (top == '0 || top == '1)
      return sh[DEF_DATA_W-1:0];
    else if (sh[DEF_ACC_W-1])
      return {1'b1, {(DEF_DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DEF_DATA_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// Combinational group MAC: LANES signed full-width multipliers summed and
// sign-extended into an ACC_W-wide partial result.
module mac_lane_tree #(
  parameter int LANES  = 5,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic [LANES-1:0][DATA_W-1:0] a,
  input  logic [LANES-1:0][DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]      sum
);

  logic signed [LANES-1:0][ACC_W-1:0] prod_ext;

  genvar l;
  generate
    for (l = 0; l < LANES; l++) begin : g_lane
      logic signed [2*DATA_W-1:0] prod;
      assign prod        = $signed(a[l]) * $signed(b[l]);
      assign prod_ext[l] = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++)
      sum = sum + $signed(prod_ext[i]);
  end

endmodule

// File: rtl/pu_window_mac.sv
// Window x weight dot-product engine fed by the PU img2col stage; accumulates
// over ch_num channels and emits one saturated result per pixel.
// Build option: define PU_MAC_RELU_EN to clamp negative results to zero.
module pu_window_mac
  import pu_mac_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WEIGHT_SIZE = 25,
  parameter int LANES       = 5,
  parameter int FRAC_BITS   = DEF_FRAC_BITS,
  parameter int ACC_W       = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [5:0]        ch_num,
  input  logic              win_valid,
  output logic              win_ready,
  input  logic [DATA_W-1:0] win_data [WEIGHT_SIZE],
  input  logic [DATA_W-1:0] wgt_data [WEIGHT_SIZE],
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
);

  localparam int G     = WEIGHT_SIZE / LANES;
  localparam int GRP_W = (G > 1) ? $clog2(G) : 1;

  mac_state_t                          state_q, state_d;
  logic signed [ACC_W-1:0]             acc_q, acc_d;
  logic [GRP_W-1:0]                    grp_q, grp_d;
  logic [5:0]                          ch_cnt_q, ch_cnt_d;
  logic [5:0]                          ch_num_q, ch_num_d;
  logic [WEIGHT_SIZE-1:0][DATA_W-1:0]  win_q, win_d;
  logic [WEIGHT_SIZE-1:0][DATA_W-1:0]  wgt_q, wgt_d;
  logic                                win_ready_q, win_ready_d;
  logic                                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]                   res_data_q, res_data_d;
  logic                                busy_q, busy_d;

  logic [LANES-1:0][DATA_W-1:0]        grp_a, grp_b;
  logic signed [ACC_W-1:0]             grp_sum;
  logic                                load;
  logic [DATA_W-1:0]                   sat_val;

  assign grp_a = win_q[grp_q*LANES +: LANES];
  assign grp_b = wgt_q[grp_q*LANES +: LANES];

  mac_lane_tree #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_tree (
    .a  (grp_a),
    .b  (grp_b),
    .sum(grp_sum)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    grp_d       = grp_q;
    ch_cnt_d    = ch_cnt_q;
    ch_num_d    = ch_num_q;
    win_ready_d = win_ready_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    load        = 1'b0;
    sat_val     = '0;

    case (state_q)
      IDLE: begin
        if (win_valid && win_ready_q) begin
          load        = 1'b1;
          acc_d       = '0;
          ch_num_d    = (ch_num == 6'd0) ? 6'd1 : ch_num;
          ch_cnt_d    = 6'd0;
          grp_d       = '0;
          win_ready_d = 1'b0;
          state_d     = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + grp_sum;
        if (grp_q == GRP_W'(G-1)) begin
          grp_d = '0;
          if (ch_cnt_q == ch_num_q - 6'd1) begin
            // Saturate from acc_d so the last group lands in this same edge.
            sat_val = sat_shift(acc_d, FRAC_BITS);
`ifdef PU_MAC_RELU_EN
            if (sat_val[DATA_W-1])
              sat_val = '0;
`endif
            res_data_d  = sat_val;
            res_valid_d = 1'b1;
            state_d     = OUT;
          end else begin
            ch_cnt_d    = ch_cnt_q + 6'd1;
            win_ready_d = 1'b1;
            state_d     = WAIT;
          end
        end else begin
          grp_d = grp_q + GRP_W'(1);
        end
      end
      WAIT: begin
        if (win_valid && win_ready_q) begin
          load        = 1'b1;
          grp_d       = '0;
          win_ready_d = 1'b0;
          state_d     = MAC;
        end
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          win_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    win_d = win_q;
    wgt_d = wgt_q;
    if (load) begin
      for (int i = 0; i < WEIGHT_SIZE; i++) begin
        win_d[i] = win_data[i];
        wgt_d[i] = wgt_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      grp_q       <= '0;
      ch_cnt_q    <= '0;
      ch_num_q    <= 6'd1;
      win_q       <= '0;
      wgt_q       <= '0;
      win_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      grp_q       <= grp_d;
      ch_cnt_q    <= ch_cnt_d;
      ch_num_q    <= ch_num_d;
      win_q       <= win_d;
      wgt_q       <= wgt_d;
      win_ready_q <= win_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
    end
  end

  assign win_ready = win_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pu_window_mac.sv
// Directed bench for pu_window_mac: latency, multi-channel accumulation,
// saturation, backpressure, mid-pixel reset and ch_num=0.
module tb_pu_window_mac;

  logic        clk = 1'b0;
  logic        nrst;
  logic [5:0]  ch_num;
  logic        win_valid;
  logic        win_ready;
  logic [15:0] win_data [25];
  logic [15:0] wgt_data [25];
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pu_window_mac dut (
    .clk      (clk),
    .nrst     (nrst),
    .ch_num   (ch_num),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_data (win_data),
    .wgt_data (wgt_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] w, input logic [15:0] g);
    for (int i = 0; i < 25; i++) begin
      win_data[i] = w;
      wgt_data[i] = g;
    end
  endtask

  // Present a window and return just after the edge on which it is accepted.
  task automatic handshake();
    int n;
    n = 0;
    win_valid = 1'b1;
    while (!win_ready && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("hs_timeout", 32'(n), 32'd0);
    tick();
    win_valid = 1'b0;
  endtask

  // Count edges from the current point until res_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  int  n;
  logic early;
  logic stable;

  initial begin
    nrst      = 1'b0;
    ch_num    = 6'd1;
    win_valid = 1'b0;
    res_ready = 1'b1;
    fill(16'h0000, 16'h0000);
    #12;
    chk("rst_win_ready", 32'(win_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    tick();
    nrst = 1'b1;
    tick();

    // 1.0 x 1.0 over 25 elements, single channel
    fill(16'h0100, 16'h0100);
    ch_num = 6'd1;
    handshake();
    chk("t1_busy",     32'(busy),      32'd1);
    chk("t1_win_rdy0", 32'(win_ready), 32'd0);
    wait_valid(n);
    chk("t1_latency",  32'(n),         32'd5);
    chk("t1_data",     32'(res_data),  32'h1900);
    tick();
    chk("t1_vld_drop", 32'(res_valid), 32'd0);
    chk("t1_idle_rdy", 32'(win_ready), 32'd1);
    chk("t1_idle_bsy", 32'(busy),      32'd0);

    // three channels of 1.0 x 0.5
    fill(16'h0100, 16'h0080);
    ch_num = 6'd3;
    early  = 1'b0;
    handshake();
    ch_num = 6'd0;
    for (int c = 0; c < 2; c++) begin
      n = 0;
      while (!win_ready && n < 40) begin
        if (res_valid) early = 1'b1;
        tick();
        n++;
      end
      chk("t2_wait_lat", 32'(n), 32'd5);
      handshake();
    end
    wait_valid(n);
    chk("t2_latency", 32'(n),        32'd5);
    chk("t2_early",   32'(early),    32'd0);
    chk("t2_data",    32'(res_data), 32'h2580);
    tick();

    // positive saturation
    ch_num = 6'd1;
    fill(16'h7FFF, 16'h7FFF);
    handshake();
    wait_valid(n);
    chk("t3_pos_data", 32'(res_data), 32'h7FFF);
    tick();

    // negative saturation
    fill(16'h7FFF, 16'h8000);
    handshake();
    wait_valid(n);
`ifdef PU_MAC_RELU_EN
    chk("t3_neg_data", 32'(res_data), 32'h0000);
`else
    chk("t3_neg_data", 32'(res_data), 32'h8000);
`endif
    tick();

    // backpressure; a second window is held throughout and must only go in after release
    res_ready = 1'b0;
    fill(16'h0100, 16'h0100);
    handshake();
    wait_valid(n);
    chk("t4_latency", 32'(n), 32'd5);
    fill(16'h0100, 16'h0200);
    win_valid = 1'b1;
    stable    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (res_valid !== 1'b1 || res_data !== 16'h1900 || win_ready !== 1'b0) stable = 1'b0;
      tick();
    end
    chk("t4_stable", 32'(stable), 32'd1);
    chk("t4_hold",   32'(res_data), 32'h1900);
    res_ready = 1'b1;
    tick();
    chk("t4_vld_drop", 32'(res_valid), 32'd0);
    chk("t4_rdy_rise", 32'(win_ready), 32'd1);
    tick();
    win_valid = 1'b0;
    chk("t4_accept_bsy", 32'(busy),      32'd1);
    chk("t4_accept_rdy", 32'(win_ready), 32'd0);
    wait_valid(n);
    chk("t4_b2b_lat",  32'(n),        32'd5);
    chk("t4_b2b_data", 32'(res_data), 32'h3200);
    tick();

    // reset in the middle of MAC
    fill(16'h0100, 16'h0100);
    handshake();
    tick();
    tick();
    nrst = 1'b0;
    #1;
    chk("t5_rst_vld", 32'(res_valid), 32'd0);
    chk("t5_rst_rdy", 32'(win_ready), 32'd1);
    chk("t5_rst_bsy", 32'(busy),      32'd0);
    tick();
    nrst = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid || !win_ready) early = 1'b1;
      tick();
    end
    chk("t5_no_partial", 32'(early), 32'd0);
    fill(16'h0000, 16'h0000);
    win_data[0] = 16'h0200;
    wgt_data[0] = 16'h0300;
    handshake();
    wait_valid(n);
    chk("t5_latency", 32'(n),        32'd5);
    chk("t5_data",    32'(res_data), 32'h0600);
    tick();

    // ch_num = 0 behaves as a single channel
    fill(16'h0000, 16'h0000);
    win_data[24] = 16'h0100;
    wgt_data[24] = 16'h0100;
    ch_num = 6'd0;
    handshake();
    wait_valid(n);
    chk("t6_latency", 32'(n),        32'd5);
    chk("t6_data",    32'(res_data), 32'h0100);
    tick();
    chk("t6_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
